// File: rtl/clk_gen_controller.sv
// rtl/clk_gen_controller.sv - programmable clock generator with glitch-free half-period reload
// Optional feature macro: CLK_GEN_TICK_EN (enables the tick pulse on each clk_salida rise).
module clk_gen_controller #(
  parameter int CLK_FPGA_HZ  = 50000000,
  parameter int DIV_WIDTH    = 24,
  parameter int DEFAULT_FREQ = 10000
) (
  input  logic                 clk_FPGA,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 cfg_req,
  input  logic [DIV_WIDTH-1:0] cfg_hp,
  output logic                 cfg_busy,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  output logic                 clk_salida,
  output logic                 running,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] DEFAULT_HP = DIV_WIDTH'((CLK_FPGA_HZ / DEFAULT_FREQ) / 2);
  localparam logic [DIV_WIDTH-1:0] ONE        = DIV_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] hp_q, hp_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 wrap;
  logic                 fall;

  // End of the current half period.
  assign wrap = (cnt_q == hp_q - ONE);

  // Next-state: divider FSM, then half-period reload handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    hp_d    = hp_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    fall    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (run) state_d = S_RUN;
      end
      S_RUN: begin
        if (!run && !clk_q) begin
          // Low phase: stopping here cannot shorten a high pulse.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (wrap) begin
            cnt_d = '0;
            clk_d = ~clk_q;
            fall  = clk_q;
          end else begin
            cnt_d = cnt_q + ONE;
          end
          if (!run) state_d = fall ? S_IDLE : S_STOPPING;
        end
      end
      S_STOPPING: begin
        // Finish the high phase, then park low.
        if (wrap) begin
          cnt_d = '0;
          clk_d = ~clk_q;
          fall  = clk_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        if (fall) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    // A new half period only takes effect on a falling edge or while idle,
    // so no shortened pulse is ever produced.
    if (busy_q) begin
      if (fall || state_q == S_IDLE) begin
        hp_d   = pend_q;
        busy_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else if (cfg_req) begin
      if (cfg_hp == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d = cfg_hp;
        busy_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hp_q    <= DEFAULT_HP;
      pend_q  <= '0;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign clk_salida = clk_q;
  assign running    = (state_q != S_IDLE);
  assign cfg_busy   = busy_q;
  assign cfg_ack    = ack_q;
  assign cfg_err    = err_q;

`ifdef CLK_GEN_TICK_EN
  logic tick_q;

  // Pulse registered on the same edge that raises clk_salida.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) tick_q <= 1'b0;
    else        tick_q <= (state_q == S_RUN) && run && wrap && !clk_q;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule
